key_filter_dual: RTL and testbench

KEY_FILTER_DUAL -- requirements
Module: key_filter_dual

---
 rtl/key_filter_dual_pkg.sv | 5 +
 rtl/key_filter_dual_if.sv | 11 +
 rtl/key_filter_dual_debounce.sv | 81 ++++++++
 rtl/key_filter_dual.sv | 34 +++
 tb/tb_key_filter_dual.sv | 139 +++++++++++++
 5 files changed

// File: rtl/key_filter_dual_pkg.sv
// key_pkg: shared debounce FSM state encoding and default filter length
package key_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} key_state_e;
  localparam int CNT_MAX_DEF = 999_999;
endpackage

// File: rtl/key_filter_dual_if.sv
// key_filter_dual_if: raw key inputs and debounced flag/level outputs of both channels
interface key_filter_dual_if;
  logic key1_in;
  logic key2_in;
  logic key1_flag;
  logic key2_flag;
  logic key1_level;
  logic key2_level;
  modport master(output key1_in, key2_in, input key1_flag, key2_flag, key1_level, key2_level);
  modport slave(input key1_in, key2_in, output key1_flag, key2_flag, key1_level, key2_level);
endinterface

// File: rtl/key_filter_dual_debounce.sv
// key_debounce: one key channel, synchronizer plus press/release filter FSM emitting a press pulse
module key_debounce
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter logic SYNC_RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic pulse,
  output logic level
);
  localparam int W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [W-1:0] MAX = W'(CNT_MAX);
  logic [1:0] sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  logic key_s, at_max;
  key_state_e state_q, state_d;
  assign key_s = sync_q[1];
  assign at_max = cnt_q == MAX;
  always_comb begin
    sync_d = {sync_q[0], key_in};
    state_d = state_q;
    cnt_d = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_FILT;
          cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (at_max) begin
          state_d = DOWN;
          cnt_d = '0;
          pulse_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      DOWN: begin
        if (key_s) begin
          state_d = REL_FILT;
          cnt_d = '0;
        end
      end
      REL_FILT: begin
        if (!key_s) begin
          state_d = DOWN;
          cnt_d = '0;
        end else if (at_max) begin
          state_d = IDLE;
          cnt_d = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{SYNC_RST_VAL}};
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
  assign level = state_q == DOWN || state_q == REL_FILT;
endmodule

// File: rtl/key_filter_dual.sv
// key_filter_dual: two debounced keys; a key2 press colliding with key1 is deferred one cycle
module key_filter_dual
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF,
  parameter logic SYNC_RST_VAL = 1'b1
) (
  input logic sys_clk,
  input logic sys_rst_n,
  key_filter_dual_if.slave kif
);
  logic p1, p2, def_q, def_d;
  key_debounce #(.CNT_MAX(CNT_MAX), .SYNC_RST_VAL(SYNC_RST_VAL)) u_key1 (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .key_in(kif.key1_in),
    .pulse(p1),
    .level(kif.key1_level)
  );
  key_debounce #(.CNT_MAX(CNT_MAX), .SYNC_RST_VAL(SYNC_RST_VAL)) u_key2 (
    .clk(sys_clk),
    .rst_n(sys_rst_n),
    .key_in(kif.key2_in),
    .pulse(p2),
    .level(kif.key2_level)
  );
  always_comb def_d = p1 & p2;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) def_q <= 1'b0;
    else def_q <= def_d;
  end
  assign kif.key1_flag = p1;
  assign kif.key2_flag = (p2 & ~p1) | def_q;
endmodule

// File: tb/tb_key_filter_dual.sv
// tb_key_filter_dual: directed scenarios with a flag scoreboard checked by a negedge monitor
module tb_key_filter_dual;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  int exp_key[$];
  int exp_cyc[$];
  key_filter_dual_if kif();
  key_filter_dual #(.CNT_MAX(9), .SYNC_RST_VAL(1'b1)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .kif(kif)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask
  task automatic pop(input int k);
    if (exp_key.size() == 0) check($sformatf("unexpected_key%0d_flag", k), 1, 0);
    else begin
      check($sformatf("key%0d_flag_id", k), k, exp_key.pop_front());
      check($sformatf("key%0d_flag_cycle", k), cyc, exp_cyc.pop_front());
    end
  endtask
  always @(negedge sys_clk) begin
    if (kif.key1_flag && kif.key2_flag) check("flag_overlap", 1, 0);
    if (kif.key1_flag) pop(1);
    if (kif.key2_flag) pop(2);
  end
  task automatic expect_flag(input int k, input int dly);
    exp_key.push_back(k);
    exp_cyc.push_back(cyc + dly);
  endtask
  task automatic drain(input string name);
    check(name, exp_key.size(), 0);
    exp_key.delete();
    exp_cyc.delete();
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic check_all_zero(input string name);
    check({name, "_key1_flag"}, kif.key1_flag, 0);
    check({name, "_key2_flag"}, kif.key2_flag, 0);
    check({name, "_key1_level"}, kif.key1_level, 0);
    check({name, "_key2_level"}, kif.key2_level, 0);
  endtask
  initial begin
    kif.key1_in = 1'b1;
    kif.key2_in = 1'b1;
    tick(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    tick(5);
    kif.key1_in = 1'b0;
    expect_flag(1, 13);
    tick(12);
    check("clean_level_before", kif.key1_level, 0);
    tick(1);
    check("clean_level_after", kif.key1_level, 1);
    tick(27);
    kif.key1_in = 1'b1;
    tick(30);
    check("clean_release_level", kif.key1_level, 0);
    drain("clean_flag_missing");
    for (int i = 0; i < 10; i++) begin
      kif.key2_in = i[0];
      tick(3);
    end
    kif.key2_in = 1'b0;
    expect_flag(2, 13);
    tick(20);
    check("bounce_level", kif.key2_level, 1);
    drain("bounce_flag_missing");
    kif.key2_in = 1'b1;
    tick(30);
    check("bounce_release_level", kif.key2_level, 0);
    kif.key1_in = 1'b0;
    tick(8);
    kif.key1_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("glitch_level", kif.key1_level, 0);
    end
    kif.key1_in = 1'b0;
    kif.key2_in = 1'b0;
    expect_flag(1, 13);
    expect_flag(2, 14);
    tick(20);
    check("simul_level1", kif.key1_level, 1);
    check("simul_level2", kif.key2_level, 1);
    drain("simul_flag_missing");
    kif.key1_in = 1'b1;
    kif.key2_in = 1'b1;
    tick(30);
    kif.key1_in = 1'b0;
    expect_flag(1, 13);
    tick(20);
    drain("hold_flag_missing");
    for (int i = 0; i < 5; i++) begin
      kif.key1_in = ~i[0];
      for (int j = 0; j < 4; j++) begin
        tick(1);
        check("rel_bounce_level", kif.key1_level, 1);
      end
    end
    kif.key1_in = 1'b0;
    tick(30);
    check("rel_bounce_hold_level", kif.key1_level, 1);
    kif.key1_in = 1'b1;
    tick(30);
    check("rel_bounce_release_level", kif.key1_level, 0);
    kif.key1_in = 1'b0;
    tick(6);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("midrst_a");
    tick(1);
    check_all_zero("midrst_b");
    tick(1);
    sys_rst_n = 1'b1;
    expect_flag(1, 13);
    tick(12);
    check("midrst_level_before", kif.key1_level, 0);
    tick(1);
    check("midrst_level_after", kif.key1_level, 1);
    tick(10);
    drain("midrst_flag_missing");
    kif.key1_in = 1'b1;
    tick(30);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
